// File: rtl/rr_bus_arbiter.sv
// Round-robin NREQ:1 bus arbiter: grants one requester at a time, steers the
// shared mux and forwards its beats downstream under valid/ready.
module rr_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    localparam int SELW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW     = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [NREQ*DATA_W-1:0] in_data,
    input  logic                   out_ready,
    output logic [NREQ-1:0]        grant,
    output logic [SELW-1:0]        out_sel,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   busy
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n;
    logic [SELW-1:0] sel_n;
    logic            busy_n;
    logic [SELW-1:0] ptr, ptr_n;
    logic [CNTW-1:0] cnt, cnt_n;

    logic            found;
    logic [SELW-1:0] pick;
    logic [SELW:0]   sum;
    logic [SELW-1:0] cand;
    logic            xfer;
    logic            release_now;
    logic [SELW-1:0] sel_inc;

    // Rotating scan starting at ptr; first requester found wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(NREQ)) begin
                sum = sum - (SELW+1)'(NREQ);
            end
            cand = sum[SELW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign out_valid = (state == OWN) && req[out_sel];
    assign out_data  = (state == OWN)
                     ? in_data[int'(out_sel)*DATA_W +: DATA_W]
                     : '0;
    assign xfer      = out_valid && out_ready;
    assign sel_inc   = (out_sel == SELW'(NREQ - 1)) ? '0 : out_sel + 1'b1;
    assign release_now = last[out_sel] || (cnt == CNTW'(MAX_BURST - 1));

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = out_sel;
        busy_n  = busy;
        ptr_n   = ptr;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = OWN;
                    grant_n = NREQ'(1) << pick;
                    sel_n   = pick;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end
            end
            OWN: begin
                if (xfer) begin
                    if (release_now) begin
                        state_n = IDLE;
                        grant_n = '0;
                        sel_n   = '0;
                        busy_n  = 1'b0;
                        ptr_n   = sel_inc;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            grant   <= '0;
            out_sel <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            out_sel <= sel_n;
            busy    <= busy_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (NREQ=4, DATA_W=8, MAX_BURST=16).
module tb_rr_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] in_data;
    logic        out_ready;
    logic [3:0]  grant;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.NREQ(4), .DATA_W(8), .MAX_BURST(16)) dut (
        .clk(clk), .resetn(resetn), .req(req), .last(last),
        .in_data(in_data), .out_ready(out_ready), .grant(grant),
        .out_sel(out_sel), .out_valid(out_valid), .out_data(out_data),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; req = '0; last = '0;
        in_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 4'b1111; last = '0;
        in_data = 32'h44332211; out_ready = 1'b1;
        repeat (2) tick();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++;
            $display("FAIL rst_grant got=%b exp=0000", grant); end
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin n_bad++;
            $display("FAIL rst_outs got v=%b b=%b d=%h exp 0/0/00", out_valid, busy, out_data); end
        resetn = 1'b1;
        tick();
        n_cmp++; if (grant !== 4'b0001 || out_sel !== 2'd0 || busy !== 1'b1) begin n_bad++;
            $display("FAIL rst_first_grant got g=%b s=%0d b=%b exp 0001/0/1", grant, out_sel, busy); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [9];
        logic [7:0] exp_d [9];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_d = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h33,
                  8'h00, 8'h44, 8'h00, 8'h11};
        do_reset();
        req = 4'b1111; last = 4'b1111; in_data = 32'h44332211;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++; if (grant !== exp_g[i] || out_data !== exp_d[i]) begin n_bad++;
                $display("FAIL rot[%0d] got g=%b d=%h exp g=%b d=%h",
                         i, grant, out_data, exp_g[i], exp_d[i]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 4'b0100; in_data[16 +: 8] = 8'hA1;
        tick();
        n_cmp++; if (grant !== 4'b0100 || out_sel !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'hA1) begin n_bad++;
            $display("FAIL stall_a1 got g=%b s=%0d v=%b d=%h exp 0100/2/1/a1", grant, out_sel, out_valid, out_data); end
        tick();
        in_data[16 +: 8] = 8'hA2; out_ready = 1'b0;
        #1;
        n_cmp++; if (out_data !== 8'hA2 || out_valid !== 1'b1) begin n_bad++;
            $display("FAIL stall_a2a got d=%h v=%b exp a2/1", out_data, out_valid); end
        tick();
        n_cmp++; if (out_data !== 8'hA2 || grant !== 4'b0100) begin n_bad++;
            $display("FAIL stall_a2b got d=%h g=%b exp a2/0100", out_data, grant); end
        out_ready = 1'b1;
        tick();
        in_data[16 +: 8] = 8'hA3; last = 4'b0100;
        #1;
        n_cmp++; if (out_data !== 8'hA3 || grant !== 4'b0100) begin n_bad++;
            $display("FAIL stall_a3 got d=%h g=%b exp a3/0100", out_data, grant); end
        tick();
        req = '0; last = '0;
        #1;
        n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++;
            $display("FAIL stall_rel got g=%b b=%b v=%b d=%h exp 0000/0/0/00", grant, busy, out_valid, out_data); end
        req = 4'b1111;
        tick();
        n_cmp++; if (grant !== 4'b1000 || out_sel !== 2'd3) begin n_bad++;
            $display("FAIL stall_ptr got g=%b s=%0d exp 1000/3", grant, out_sel); end
    endtask

    task automatic test_max_burst();
        int bad_hold = 0;
        do_reset();
        req = 4'b1010; in_data = 32'h77665544;
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++;
            $display("FAIL burst_grant got=%b exp=0010", grant); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (grant !== 4'b0010) bad_hold++;
        end
        n_cmp++; if (bad_hold !== 0) begin n_bad++;
            $display("FAIL burst_hold got %0d early releases exp 0", bad_hold); end
        tick();
        n_cmp++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_bad++;
            $display("FAIL burst_release got g=%b b=%b exp 0000/0", grant, busy); end
        tick();
        n_cmp++; if (grant !== 4'b1000) begin n_bad++;
            $display("FAIL burst_next got=%b exp=1000", grant); end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0001; in_data = 32'h00000055;
        tick();
        tick();
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b0 || grant !== 4'b0001) begin n_bad++;
                $display("FAIL drop[%0d] got v=%b g=%b exp 0/0001", i, out_valid, grant); end
            tick();
        end
        req = 4'b0011;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || grant !== 4'b0001 || out_data !== 8'h55) begin n_bad++;
            $display("FAIL drop_resume got v=%b g=%b d=%h exp 1/0001/55", out_valid, grant, out_data); end
        last = 4'b0001;
        tick();
        last = 4'b0000;
        n_cmp++; if (grant !== 4'b0000) begin n_bad++;
            $display("FAIL drop_rel got=%b exp=0000", grant); end
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++;
            $display("FAIL drop_next got=%b exp=0010", grant); end
    endtask

    task automatic test_midreset();
        do_reset();
        req = 4'b0001; last = 4'b0001;
        tick();
        tick();
        req = 4'b0100; last = 4'b0000; in_data = 32'h00990000;
        tick();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++;
            $display("FAIL mrst_own got=%b exp=0100", grant); end
        tick();
        resetn = 1'b0;
        tick();
        n_cmp++; if (grant !== 4'b0000 || out_sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++;
            $display("FAIL mrst_outs got g=%b s=%0d b=%b v=%b d=%h exp all 0", grant, out_sel, busy, out_valid, out_data); end
        resetn = 1'b1; req = 4'b0101;
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++;
            $display("FAIL mrst_ptr got=%b exp=0001", grant); end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_stall();
        test_max_burst();
        test_drop();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1);
    end

endmodule
